// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage MIPS32 pipeline: EX-stage operand
// forwarding, load-use stall detection and branch resolution sequencing.
module hazard_controller #(
    parameter int BRANCH_LAT = 2,
    parameter int REG_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic [REG_W-1:0] rs_e,
    input  logic [REG_W-1:0] rt_e,
    input  logic [REG_W-1:0] write_reg_e,
    input  logic             reg_write_e,
    input  logic             mem_to_reg_e,
    input  logic             branch_e,
    input  logic [REG_W-1:0] write_reg_m,
    input  logic             reg_write_m,
    input  logic [REG_W-1:0] write_reg_w,
    input  logic             reg_write_w,
    input  logic             branch_taken,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             pc_src,
    output logic             resume,
    output logic             busy
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] BR_WAIT  = 2'd1;
    localparam logic [1:0] BR_FLUSH = 2'd2;

    // Counter preload: the last BR_WAIT cycle is the one where the count is 0.
    localparam logic [2:0] CNT_INIT = 3'(BRANCH_LAT - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       resume_q, resume_d;
    logic       lu;

    // Load in EX whose destination is read by the instruction in decode.
    always_comb begin
        lu = mem_to_reg_e && reg_write_e && (write_reg_e != '0) &&
             ((write_reg_e == rs_d) || (write_reg_e == rt_d));
    end

    // Branch sequencing next-state logic; lu never changes state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        resume_d = 1'b0;
        case (state_q)
            RUN: begin
                if (branch_e) begin
                    state_d = BR_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            BR_WAIT: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else if (branch_taken) begin
                    state_d = BR_FLUSH;
                end else begin
                    state_d  = RUN;
                    resume_d = 1'b1;
                end
            end
            BR_FLUSH: begin
                state_d  = RUN;
                resume_d = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State, wait counter and registered resume pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            resume_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            resume_q <= resume_d;
        end
    end

    // Output decode; everything is held low while reset is asserted.
    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        pc_src      = 1'b0;
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        resume      = 1'b0;
        busy        = 1'b0;
        if (!rst) begin
            if (reg_write_m && (write_reg_m != '0) && (write_reg_m == rs_e)) begin
                forward_a_e = 2'b10;
            end else if (reg_write_w && (write_reg_w != '0) && (write_reg_w == rs_e)) begin
                forward_a_e = 2'b01;
            end
            if (reg_write_m && (write_reg_m != '0) && (write_reg_m == rt_e)) begin
                forward_b_e = 2'b10;
            end else if (reg_write_w && (write_reg_w != '0) && (write_reg_w == rt_e)) begin
                forward_b_e = 2'b01;
            end
            resume = resume_q;
            busy   = (state_q != RUN);
            case (state_q)
                RUN: begin
                    // A branch entering BR_WAIT takes precedence over the stall.
                    stall_f = lu && !branch_e;
                    stall_d = lu && !branch_e;
                    flush_e = lu && !branch_e;
                end
                BR_WAIT: begin
                    stall_f = 1'b1;
                    flush_d = 1'b1;
                end
                BR_FLUSH: begin
                    pc_src  = 1'b1;
                    flush_d = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed vector table, hand
// sequences for branch timing, then random stimulus against a queue model.
module tb_hazard_controller;

    localparam int BL = 2;
    localparam int RW = 5;

    logic          clk;
    logic          rst;
    logic [RW-1:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
    logic          reg_write_e, mem_to_reg_e, branch_e, reg_write_m, reg_write_w, branch_taken;
    logic          stall_f, stall_d, flush_d, flush_e, pc_src, resume, busy;
    logic [1:0]    forward_a_e, forward_b_e;

    int checks = 0;
    int errors = 0;

    hazard_controller #(.BRANCH_LAT(BL), .REG_W(RW)) dut (
        .clk(clk), .rst(rst),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .write_reg_e(write_reg_e), .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
        .branch_e(branch_e),
        .write_reg_m(write_reg_m), .reg_write_m(reg_write_m),
        .write_reg_w(write_reg_w), .reg_write_w(reg_write_w),
        .branch_taken(branch_taken),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .pc_src(pc_src), .resume(resume), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output bundle: {stall_f, stall_d, flush_d, flush_e, pc_src, resume, busy, fa, fb}
    localparam logic [10:0] IDLE_V   = 11'b000_0000_0000;
    localparam logic [10:0] WAIT_V   = 11'b101_0001_0000;
    localparam logic [10:0] FLUSH_V  = 11'b001_0101_0000;
    localparam logic [10:0] RESUME_V = 11'b000_0010_0000;

    typedef struct {
        logic [RW-1:0] rs_d, rt_d, rs_e, rt_e, wre;
        logic          rwe, m2r;
        logic [RW-1:0] wrm;
        logic          rwm;
        logic [RW-1:0] wrw;
        logic          rww;
        logic [1:0]    fa, fb;
        logic          stl;
    } vec_t;

    vec_t vecs[11];

    // Branch model: queue of upcoming phases. 0 = wait, 1 = flush, 2 = resume.
    int q[$];

    function automatic vec_t mk(input int a_rs_d, input int a_rt_d, input int a_rs_e,
                                input int a_rt_e, input int a_wre, input int a_rwe,
                                input int a_m2r, input int a_wrm, input int a_rwm,
                                input int a_wrw, input int a_rww, input int a_fa,
                                input int a_fb, input int a_stl);
        vec_t v;
        v.rs_d = RW'(a_rs_d); v.rt_d = RW'(a_rt_d); v.rs_e = RW'(a_rs_e); v.rt_e = RW'(a_rt_e);
        v.wre  = RW'(a_wre);  v.rwe = (a_rwe != 0);   v.m2r = (a_m2r != 0);
        v.wrm  = RW'(a_wrm);  v.rwm = (a_rwm != 0);   v.wrw = RW'(a_wrw);
        v.rww  = (a_rww != 0); v.fa = 2'(a_fa); v.fb = 2'(a_fb); v.stl = (a_stl != 0);
        return v;
    endfunction

    function automatic logic [10:0] dut_out();
        return {stall_f, stall_d, flush_d, flush_e, pc_src, resume, busy, forward_a_e, forward_b_e};
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [RW-1:0] src);
        if (reg_write_m && write_reg_m != 0 && write_reg_m == src) return 2'b10;
        if (reg_write_w && write_reg_w != 0 && write_reg_w == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [10:0] model_out();
        int   ph;
        logic stl;
        if (rst) return '0;
        ph  = (q.size() == 0) ? 3 : q[0];
        stl = mem_to_reg_e && reg_write_e && write_reg_e != 0 &&
              (write_reg_e == rs_d || write_reg_e == rt_d) && !branch_e;
        case (ph)
            0:       return {WAIT_V[10:4], ref_fwd(rs_e), ref_fwd(rt_e)};
            1:       return {FLUSH_V[10:4], ref_fwd(rs_e), ref_fwd(rt_e)};
            2:       return {stl, stl, 1'b0, stl, 1'b0, 1'b1, 1'b0, ref_fwd(rs_e), ref_fwd(rt_e)};
            default: return {stl, stl, 1'b0, stl, 1'b0, 1'b0, 1'b0, ref_fwd(rs_e), ref_fwd(rt_e)};
        endcase
    endfunction

    // Advance the model at a clock edge using the inputs of the ending cycle.
    task automatic model_step();
        int ph;
        if (rst) begin
            q.delete();
        end else begin
            ph = (q.size() == 0) ? 3 : q[0];
            if (ph == 3 || ph == 2) begin
                if (ph == 2) void'(q.pop_front());
                if (branch_e) for (int i = 0; i < BL; i++) q.push_back(0);
            end else if (ph == 0) begin
                void'(q.pop_front());
                if (q.size() == 0) begin
                    if (branch_taken) q.push_back(1);
                    q.push_back(2);
                end
            end else begin
                void'(q.pop_front());
            end
        end
    endtask

    task automatic compare(input string name, input logic [10:0] exp);
        logic [10:0] act;
        act = dut_out();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (sf sd fd fe pc rs bz fa fb)", name, act, exp);
        end
    endtask

    // Check mid-cycle, then move to just after the next rising edge.
    task automatic cyc_chk(input string name, input logic [10:0] exp);
        @(negedge clk);
        compare(name, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0; write_reg_e = '0;
        reg_write_e = 1'b0; mem_to_reg_e = 1'b0; branch_e = 1'b0;
        write_reg_m = '0; reg_write_m = 1'b0; write_reg_w = '0; reg_write_w = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic set_lu();
        mem_to_reg_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd5; rt_d = 5'd5;
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 8, 9, 0, 0, 0, 8, 1, 8, 1, 2, 0, 0);
        vecs[1]  = mk(0, 0, 8, 9, 0, 0, 0, 0, 1, 8, 1, 1, 0, 0);
        vecs[2]  = mk(0, 0, 0, 9, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        vecs[3]  = mk(0, 0, 3, 9, 0, 0, 0, 3, 1, 9, 1, 2, 1, 0);
        vecs[4]  = mk(0, 0, 8, 8, 0, 0, 0, 8, 0, 8, 0, 0, 0, 0);
        vecs[5]  = mk(0, 5, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        vecs[6]  = mk(7, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        vecs[7]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[8]  = mk(0, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(0, 5, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[10] = mk(4, 6, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0);

        clear_inputs();
        rst = 1'b1;
        // Reset must mask combinational outputs even with a forwarding match present.
        reg_write_m = 1'b1; write_reg_m = 5'd8; rs_e = 5'd8;
        cyc_chk("reset_forced_zero", IDLE_V);
        clear_inputs();
        rst = 1'b0;
        cyc_chk("idle_after_reset", IDLE_V);

        foreach (vecs[i]) begin
            rs_d = vecs[i].rs_d; rt_d = vecs[i].rt_d; rs_e = vecs[i].rs_e; rt_e = vecs[i].rt_e;
            write_reg_e = vecs[i].wre; reg_write_e = vecs[i].rwe; mem_to_reg_e = vecs[i].m2r;
            write_reg_m = vecs[i].wrm; reg_write_m = vecs[i].rwm;
            write_reg_w = vecs[i].wrw; reg_write_w = vecs[i].rww;
            cyc_chk($sformatf("vec%0d", i),
                    {vecs[i].stl, vecs[i].stl, 1'b0, vecs[i].stl, 3'b000, vecs[i].fa, vecs[i].fb});
        end
        clear_inputs();

        // Branch not taken; an early branch_taken must be ignored.
        branch_e = 1'b1;                         cyc_chk("nt_ex", IDLE_V);
        branch_e = 1'b0; branch_taken = 1'b1;    cyc_chk("nt_wait1", WAIT_V);
        branch_taken = 1'b0;                     cyc_chk("nt_wait2", WAIT_V);
        cyc_chk("nt_resume", RESUME_V);
        cyc_chk("nt_after", IDLE_V);

        // Branch taken.
        branch_e = 1'b1;                         cyc_chk("tk_ex", IDLE_V);
        branch_e = 1'b0;                         cyc_chk("tk_wait1", WAIT_V);
        branch_taken = 1'b1;                     cyc_chk("tk_wait2", WAIT_V);
        branch_taken = 1'b0;                     cyc_chk("tk_flush", FLUSH_V);
        cyc_chk("tk_resume", RESUME_V);
        cyc_chk("tk_after", IDLE_V);

        // branch_e beats lu; re-pulsed branch_e and lu ignored while waiting.
        set_lu(); branch_e = 1'b1;               cyc_chk("pri_ex", IDLE_V);
        cyc_chk("pri_wait1", WAIT_V);
        branch_e = 1'b0;                         cyc_chk("pri_wait2", WAIT_V);
        clear_inputs();                          cyc_chk("pri_resume", RESUME_V);
        cyc_chk("pri_after", IDLE_V);

        // Reset during BR_WAIT aborts without a resume pulse.
        branch_e = 1'b1;                         cyc_chk("rst_ex", IDLE_V);
        branch_e = 1'b0;                         cyc_chk("rst_wait1", WAIT_V);
        rst = 1'b1;                              cyc_chk("rst_mid_wait", IDLE_V);
        rst = 1'b0;                              cyc_chk("rst_no_resume", IDLE_V);
        cyc_chk("rst_idle", IDLE_V);

        // Random stimulus against the phase-queue model; first cycle resets.
        for (int n = 0; n < 3000; n++) begin
            rs_d = RW'($urandom_range(0, 3)); rt_d = RW'($urandom_range(0, 3));
            rs_e = RW'($urandom_range(0, 3)); rt_e = RW'($urandom_range(0, 3));
            write_reg_e = RW'($urandom_range(0, 3));
            write_reg_m = RW'($urandom_range(0, 3));
            write_reg_w = RW'($urandom_range(0, 3));
            reg_write_e  = 1'($urandom_range(0, 1));
            mem_to_reg_e = 1'($urandom_range(0, 1));
            reg_write_m  = 1'($urandom_range(0, 1));
            reg_write_w  = 1'($urandom_range(0, 1));
            branch_taken = 1'($urandom_range(0, 1));
            branch_e     = ($urandom_range(0, 7) == 0);
            rst          = (n == 0) || ($urandom_range(0, 99) == 0);
            @(negedge clk);
            compare($sformatf("rand%0d", n), model_out());
            @(posedge clk);
            model_step();
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencing block for the 5-stage MIPS32 core: detects load-use hazards, selects EX-stage operand forwarding, and sequences branch resolution.
- Drives stall/flush enables to fetch, decode and execute pipeline registers.
- Issues a one-cycle `resume` pulse that clears the decode stage's branch stall.
- Sits beside the datapath, taking register indices and control bits from the D/E/M/W stages.

Parameters:
- BRANCH_LAT, 2, cycles a branch spends in BR_WAIT from its EX cycle until `branch_taken` is valid (legal range 1..7).
- REG_W, 5, register index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rs_d  in  REG_W  source reg 1 of instruction in decode
- rt_d  in  REG_W  source reg 2 of instruction in decode
- rs_e  in  REG_W  source reg 1 of instruction in execute
- rt_e  in  REG_W  source reg 2 of instruction in execute
- write_reg_e  in  REG_W  destination in execute
- reg_write_e  in  1  execute instr writes a register
- mem_to_reg_e  in  1  execute instr is a load
- branch_e  in  1  execute instr is a branch (valid one cycle)
- write_reg_m  in  REG_W  destination in memory stage
- reg_write_m  in  1  memory-stage register write
- write_reg_w  in  REG_W  destination in writeback
- reg_write_w  in  1  writeback register write
- branch_taken  in  1  branch outcome, sampled only on last BR_WAIT cycle
- stall_f  out  1  hold PC/fetch register
- stall_d  out  1  hold decode register
- flush_d  out  1  squash decode register (insert bubble)
- flush_e  out  1  squash execute register (insert bubble)
- forward_a_e  out  2  operand A source: 00 regfile, 01 WB, 10 MEM
- forward_b_e  out  2  operand B source, same encoding
- pc_src  out  1  redirect fetch to branch target
- resume  out  1  one-cycle pulse releasing the decode stall
- busy  out  1  state != RUN

Behaviour:
- Reset: synchronous, active-high. State = RUN, counter = 0, `resume` = 0. While `rst`=1, every output is forced to 0, including the combinational ones. Reset mid-BR_WAIT aborts the branch with no `resume` pulse.
- Forwarding (combinational, any state), per operand:
  - 10 if reg_write_m && write_reg_m != 0 && write_reg_m == rs_e (rt_e for B).
  - Else 01 if the same match holds against the W stage.
  - Else 00.
  - MEM has priority over WB. Register 0 is never forwarded.
- Load-use hazard lu = mem_to_reg_e && reg_write_e && write_reg_e != 0 && (write_reg_e == rs_d || write_reg_e == rt_d).
  - In RUN, lu drives stall_f = stall_d = flush_e = 1 combinationally for that cycle only.
  - lu clears naturally once the load advances. No state change.
- FSM states: RUN, BR_WAIT, BR_FLUSH.
  - RUN, branch_e = 1: go to BR_WAIT, counter <= BRANCH_LAT-1. `branch_e` wins over lu; they cannot legally coincide because both describe the EX instruction.
  - BR_WAIT: stall_f = 1, flush_d = 1, stall_d = 0. If counter != 0, decrement. If counter == 0, sample `branch_taken`: taken goes to BR_FLUSH; not taken goes to RUN with `resume` <= 1.
  - BR_FLUSH (exactly 1 cycle): pc_src = 1, flush_d = 1, stall_f = 0. Next state RUN with `resume` <= 1.
  - `resume` is registered. It is high exactly the first RUN cycle after BR_WAIT or BR_FLUSH, 0 otherwise.
  - In BR_WAIT/BR_FLUSH, lu and branch_e are ignored; the pipeline is bubbled.
- busy = (state != RUN), combinational from state.
- Branch latency, not taken: EX cycle + BRANCH_LAT wait cycles, then RUN.
- Branch latency, taken: EX cycle + BRANCH_LAT wait cycles + 1 flush cycle, then RUN.
- Counter width is 3 bits; BRANCH_LAT = 1 means a single BR_WAIT cycle that samples immediately.

Test Plan:
- Reset, then idle with all inputs 0 -> all outputs 0, busy = 0. Assert `rst` in BR_WAIT -> next cycle state RUN, resume = 0.
- Forwarding: reg_write_m = 1, write_reg_m = 8, reg_write_w = 1, write_reg_w = 8, rs_e = 8, rt_e = 9 -> forward_a_e = 10, forward_b_e = 00. Set write_reg_m = 0 -> forward_a_e = 01. Set write_reg_w = 0 too, rs_e = 0 -> 00.
- Load-use: mem_to_reg_e = 1, reg_write_e = 1, write_reg_e = 5, rt_d = 5 -> stall_f = stall_d = flush_e = 1 for one cycle. Same with write_reg_e = 0 -> no stall.
- Branch not taken, BRANCH_LAT = 2: branch_e pulse at cycle 0 -> busy = 1, stall_f = flush_d = 1 on cycles 1-2. branch_taken = 0 at cycle 2 -> resume = 1 at cycle 3 only, pc_src never 1.
- Branch taken, BRANCH_LAT = 2: branch_taken = 1 at cycle 2 -> pc_src = 1, flush_d = 1 at cycle 3; resume = 1 at cycle 4; busy = 0 from cycle 4.
- Priority/ignore: branch_e and lu both high in RUN -> enter BR_WAIT, flush_e = 0. branch_e re-pulsed during BR_WAIT -> no restart, counter unaffected.
